// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter family: direction
// encodings, default geometry and the wrapped next-value function.
package mod_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 12;

  // Widest supported counter; next_count works on this width and callers
  // truncate back to their own WIDTH.
  localparam int MAX_WIDTH = 16;

  typedef logic [MAX_WIDTH-1:0] cnt_t;
  // One extra bit so a modulus of 2**MAX_WIDTH is representable.
  typedef logic [MAX_WIDTH:0]   mod_t;

  // Next count value in the given direction, wrapping inside 0..modulus-1.
  // The compare against modulus-1 (rather than relying on natural rollover)
  // keeps the result correct for any modulus, including a full power of two.
  function automatic cnt_t next_count(input cnt_t cq, input logic up_dn, input mod_t modulus);
    mod_t cq_ext;
    mod_t last;
    mod_t nxt;
    cq_ext = {1'b0, cq};
    last   = modulus - 17'd1;
    if (up_dn == DIR_UP) begin
      if (cq_ext == last) begin
        nxt = 17'd0;
      end else begin
        nxt = cq_ext + 17'd1;
      end
    end else begin
      if (cq_ext == 17'd0) begin
        nxt = last;
      end else begin
        nxt = cq_ext - 17'd1;
      end
    end
    return nxt[MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mod_counter_ud.sv
// Parametrised modulo-N up/down counter with synchronous clear/load,
// enable, combinational terminal count (tc) for cascading and a registered
// wrap pulse. Optional one-shot mode (stop at the terminal value instead of
// wrapping, flagged on done) is built when MOD_COUNTER_ONESHOT_EN is defined.
module mod_counter_ud
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_ONESHOT_EN
  input  logic             oneshot,
  output logic             done,
`endif
  output logic [WIDTH-1:0] cq,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_CNT = {WIDTH{1'b0}};
  localparam mod_t             MOD_EXT  = mod_t'(MODULUS);

  // Reject illegal geometry at elaboration time.
  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "mod_counter_ud: WIDTH %0d outside 2..%0d", WIDTH, MAX_WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "mod_counter_ud: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  logic             term_s;      // cq sits at the terminal value for the current direction
  logic             stopped_s;   // one-shot run complete: counting frozen
  logic             oneshot_s;   // one-shot mode requested
  logic [WIDTH-1:0] step_s;      // wrapped next value in the current direction
  logic [WIDTH-1:0] load_sat_s;  // load value clamped to MODULUS-1
  logic [WIDTH-1:0] cq_nxt_s;
  logic             wrap_nxt_s;

`ifdef MOD_COUNTER_ONESHOT_EN
  logic done_r;
  logic done_nxt_s;

  assign stopped_s = done_r;
  assign oneshot_s = oneshot;
  assign done      = done_r;
`else
  assign stopped_s = 1'b0;
  assign oneshot_s = 1'b0;
`endif

  // Terminal detection, stepped value and saturated load value.
  always_comb begin
    term_s     = 1'b0;
    step_s     = WIDTH'(next_count(cnt_t'(cq), up_dn, MOD_EXT));
    load_sat_s = load_val;
    if (up_dn == DIR_UP) begin
      term_s = (cq == LAST_CNT);
    end else begin
      term_s = (cq == ZERO_CNT);
    end
    if (load_val > LAST_CNT) begin
      load_sat_s = LAST_CNT;
    end else begin
      load_sat_s = load_val;
    end
  end

  // tc is deliberately ungated by clr/load so a cascade sees it immediately.
  assign tc = en & term_s & ~stopped_s;

  // Next count and wrap pulse with priority clr > load > en > hold.
  always_comb begin
    cq_nxt_s   = cq;
    wrap_nxt_s = 1'b0;
    if (clr) begin
      cq_nxt_s = ZERO_CNT;
    end else if (load) begin
      cq_nxt_s = load_sat_s;
    end else if (en && !stopped_s) begin
      if (term_s && oneshot_s) begin
        cq_nxt_s = cq;
      end else begin
        cq_nxt_s   = step_s;
        wrap_nxt_s = term_s;
      end
    end else begin
      cq_nxt_s = cq;
    end
  end

`ifdef MOD_COUNTER_ONESHOT_EN
  // One-shot completion flag: set on the step that would wrap, cleared by clr/load.
  always_comb begin
    done_nxt_s = done_r;
    if (clr || load) begin
      done_nxt_s = 1'b0;
    end else if (en && !done_r && term_s && oneshot_s) begin
      done_nxt_s = 1'b1;
    end else begin
      done_nxt_s = done_r;
    end
  end

  // Done flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_nxt_s;
    end
  end
`endif

  // Count and wrap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cq   <= ZERO_CNT;
      wrap <= 1'b0;
    end else begin
      cq   <= cq_nxt_s;
      wrap <= wrap_nxt_s;
    end
  end

endmodule

// File: doc/mod_counter_ud.md
Name: mod_counter_ud

Overview:
Parametrised modulo-N up/down counter with synchronous clear and load, enable, combinational terminal-count output for cascading, and a registered wrap pulse.
Generalises the fixed mod-12 counter used by the 8-way running-light system, including its decode of the final count.
Instances drive running-light sequencers, cascaded prescalers and debounce timers.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..16.
MODULUS, 12, number of states. The count runs 0..MODULUS-1. Legal range 2..2**WIDTH.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  count enable; one step per clock while high
up_dn  in  1  1 = count up, 0 = count down
clr  in  1  synchronous clear to 0
load  in  1  synchronous load
load_val  in  WIDTH  value applied on load
cq  out  WIDTH  current count (registered)
tc  out  1  terminal count (combinational, for cascading)
wrap  out  1  registered one-cycle pulse after a wrap

Behaviour:
- Reset: rst high asynchronously forces cq=0 and wrap=0. The counter holds these values while rst is high. Counting resumes at the first rising edge after rst falls.
- Per-edge priority: clr > load > en > hold.
- clr: cq<=0. No wrap pulse.
- load: cq<=load_val if load_val<=MODULUS-1, otherwise cq<=MODULUS-1 (saturate). No wrap pulse. Overrides en in the same cycle.
- Count up (en=1, up_dn=1): if cq==MODULUS-1 then cq<=0, else cq<=cq+1.
- Count down (en=1, up_dn=0): if cq==0 then cq<=MODULUS-1, else cq<=cq-1.
- Arithmetic: all in WIDTH bits, with no overflow past MODULUS-1. For MODULUS==2**WIDTH the natural rollover must give the same result.
- tc = en & ((up_dn & cq==MODULUS-1) | (~up_dn & cq==0)).
  - tc is combinational, with no gating by clr/load.
  - It drives the next stage's en when counters are cascaded.
- wrap: registered. High for exactly one cycle following any edge on which a count wrapped (up or down) and neither clr nor load was active. Otherwise 0.
- up_dn may change on any cycle. It takes effect on the same edge, and tc follows immediately.
- Elaboration check: MODULUS outside 2..2**WIDTH is a fatal error.

Optional Feature:
Macro MOD_COUNTER_ONESHOT_EN.

Defined:
- Adds input port oneshot (1 bit) and output port done (1 bit, reset 0).
- With oneshot=1, reaching the terminal value stops the counter instead of wrapping:
  - Up-count stops at cq=MODULUS-1; down-count stops at cq=0.
  - done<=1 is registered on the step that completes the run, i.e. the step that would otherwise wrap.
  - While done=1: en is ignored, tc=0, and wrap stays 0.
- clr or load clears done and restarts normal operation.
- With oneshot=0, behaviour is identical to the build without the macro; done remains 0.

Undefined:
- Ports oneshot and done are absent.
- The counter always wraps.

Decomposition:
- Package mod_counter_pkg contains:
  - localparams DIR_UP=1'b1 and DIR_DN=1'b0;
  - defaults DEF_WIDTH=4 and DEF_MODULUS=12;
  - a pure function next_count(cq, up_dn, modulus) that returns the wrapped next value.
- No sub-module: a single flat block.
- Cascading is done by connecting tc to the next instance's en at the instance level.

Test Plan (WIDTH=4, MODULUS=12 unless stated):
1. Reset, then en=1, up_dn=1 for 14 clocks → cq steps 0..11, 0, 1. tc is high only while cq=11. wrap is high for the one cycle with cq=0 after the wrap.
2. From cq=2, up_dn=0 for 4 clocks → cq 1, 0, 11, 10. tc is high while cq=0. wrap pulses once, after the 0→11 wrap.
3. load=1 with load_val=7 and en=1 in the same cycle → cq=7, no wrap. load_val=14 → cq=11 (saturated). Asserting clr and load together → cq=0.
4. rst pulsed mid-count at cq=9, between clock edges → cq=0 and wrap=0 immediately, with no clock required. Counting resumes 1, 2, … after rst falls.
5. Two instances cascaded (MODULUS=12 and 5, tc0→en1) for 60 clocks → the upper counter advances once per 12 clocks and ends at 0. The upper instance's wrap pulses exactly once.
6. MOD_COUNTER_ONESHOT_EN build, oneshot=1, up-count from 0 → cq stops at 11 and done=1 after the 12th step. Further en has no effect and wrap stays 0. clr then sets cq=0 and done=0.
